// File: rtl/booth_r4_mult_pipe_pkg.sv
// Shared constants and Booth digit decode for the
// pipelined radix-4 fixed-point multiplier.
package iir_mult_pkg;

  localparam logic [1:0] RND_TRUNC     = 2'b00;
  localparam logic [1:0] RND_HALF_UP   = 2'b01;
  localparam logic [1:0] RND_HALF_EVEN = 2'b10;

  typedef struct packed {
    logic zero;
    logic neg;
    logic x2;
  } booth_sel_t;

  function automatic booth_sel_t booth_r4_digit(
    input logic [2:0] grp
  );
    booth_sel_t sel;
    sel.zero = (grp == 3'b000) || (grp == 3'b111);
    sel.neg  = grp[2];
    sel.x2   = (grp == 3'b011) || (grp == 3'b100);
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_mult_pipe_if.sv
// Operand/result handshake bundle for the
// pipelined Booth multiplier.
interface booth_r4_mult_pipe_if #(
  parameter int W = 24
) ();
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   rnd_mode;
  logic         valid_in;
  logic         ready_in;
  logic [W-1:0] p;
  logic         sat;
  logic         valid_out;
  logic         ready_out;

  modport master (
    output a, b, rnd_mode, valid_in, ready_out,
    input  ready_in, p, sat, valid_out
  );

  modport slave (
    input  a, b, rnd_mode, valid_in, ready_out,
    output ready_in, p, sat, valid_out
  );
endinterface

// File: rtl/booth_r4_mult_pipe_pp_gen.sv
// One radix-4 Booth partial product, unshifted,
// sign-extended to twice the operand width.
module booth_r4_pp_gen
  import iir_mult_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0]          b_i,
  input  logic [2:0]            grp_i,
  output logic signed [2*W-1:0] pp_o
);

  booth_sel_t            sel;
  logic signed [2*W-1:0] bx;
  logic signed [2*W-1:0] mag;

  always_comb begin
    sel  = booth_r4_digit(grp_i);
    bx   = {{W{b_i[W-1]}}, b_i};
    mag  = sel.x2 ? (bx <<< 1) : bx;
    pp_o = sel.zero ? '0 : (sel.neg ? -mag : mag);
  end

endmodule

// File: rtl/booth_r4_mult_pipe.sv
// Fully pipelined radix-4 Booth signed fixed-point
// multiplier with rounding, saturation and backpressure.
module booth_r4_mult_pipe
  import iir_mult_pkg::*;
#(
  parameter int W            = 24,
  parameter int FRAC         = 22,
  parameter int PP_PER_STAGE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  booth_r4_mult_pipe_if.slave bus
);

  localparam int NPP = W / 2;
  localparam int NS  = (NPP + PP_PER_STAGE - 1) / PP_PER_STAGE;
  localparam int W2  = 2 * W;

  localparam logic signed [W2:0] MAXV =
    $signed({{(W+2){1'b0}}, {(W-1){1'b1}}});
  localparam logic signed [W2:0] MINV =
    $signed({{(W+2){1'b1}}, {(W-1){1'b0}}});
  localparam logic [FRAC-1:0] HALF =
    FRAC'(1) << (FRAC-1);

  logic [W-1:0]           a_q   [NS];
  logic [W-1:0]           b_q   [NS];
  logic [1:0]             m_q   [NS+1];
  logic                   v_q   [NS+1];
  logic signed [W2-1:0]   acc_q [NS+1];
  logic signed [W2-1:0]   acc_d [NS];
  logic signed [W2-1:0]   pp    [NPP];

  logic [W-1:0]           p_q;
  logic [W-1:0]           p_d;
  logic                   sat_q;
  logic                   sat_d;
  logic                   vo_q;
  logic                   en;

  logic signed [W2:0]     pf;
  logic signed [W2:0]     r_full;
  logic signed [W2:0]     rd;
  logic [FRAC-1:0]        rem;
  logic                   up;

  assign en            = !vo_q || bus.ready_out;
  assign bus.ready_in  = en;
  assign bus.p         = p_q;
  assign bus.sat       = sat_q;
  assign bus.valid_out = vo_q;

  // Group j reads the a/b copy travelling with the stage that sums it
  for (genvar j = 0; j < NPP; j++) begin : g_pp
    localparam int S = j / PP_PER_STAGE;
    logic [2:0] grp;
    if (j == 0) begin : g_lo
      assign grp = {a_q[S][1:0], 1'b0};
    end else begin : g_hi
      assign grp = a_q[S][2*j+1:2*j-1];
    end
    booth_r4_pp_gen #(
      .W(W)
    ) u_pp (
      .b_i  (b_q[S]),
      .grp_i(grp),
      .pp_o (pp[j])
    );
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      acc_d[s] = acc_q[s];
      for (int j = s * PP_PER_STAGE;
           j < NPP && j < (s + 1) * PP_PER_STAGE;
           j++) begin
        acc_d[s] = acc_d[s] + (pp[j] <<< (2 * j));
      end
    end
  end

  // One extra bit of headroom keeps the rounding increment exact
  always_comb begin
    pf     = {acc_q[NS][W2-1], acc_q[NS]};
    r_full = pf >>> FRAC;
    rem    = acc_q[NS][FRAC-1:0];
    unique case (m_q[NS])
      RND_HALF_UP:     up = (rem >= HALF);
      RND_HALF_EVEN:   up = (rem > HALF) ||
                            ((rem == HALF) && r_full[0]);
      RND_TRUNC, 2'b11: up = 1'b0;
    endcase
    rd = r_full + (W2+1)'(up);
    if (rd > MAXV) begin
      p_d   = MAXV[W-1:0];
      sat_d = 1'b1;
    end else if (rd < MINV) begin
      p_d   = MINV[W-1:0];
      sat_d = 1'b1;
    end else begin
      p_d   = rd[W-1:0];
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
      end
      for (int s = 0; s <= NS; s++) begin
        m_q[s]   <= '0;
        v_q[s]   <= 1'b0;
        acc_q[s] <= '0;
      end
      p_q   <= '0;
      sat_q <= 1'b0;
      vo_q  <= 1'b0;
    end else if (en) begin
      a_q[0]   <= bus.a;
      b_q[0]   <= bus.b;
      m_q[0]   <= bus.rnd_mode;
      v_q[0]   <= bus.valid_in;
      acc_q[0] <= '0;
      for (int s = 0; s < NS - 1; s++) begin
        a_q[s+1] <= a_q[s];
        b_q[s+1] <= b_q[s];
      end
      for (int s = 0; s < NS; s++) begin
        m_q[s+1]   <= m_q[s];
        v_q[s+1]   <= v_q[s];
        acc_q[s+1] <= acc_d[s];
      end
      p_q   <= p_d;
      sat_q <= sat_d;
      vo_q  <= v_q[NS];
    end
  end

endmodule

// File: tb/tb_booth_r4_mult_pipe.sv
// Randomised and directed checks of the Booth multiplier
// against an arithmetic reference model.
module tb_booth_r4_mult_pipe;
  import iir_mult_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   nvec  = 0;
  int   nerr  = 0;
  int   cyc   = 0;
  int   n_out0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_r4_mult_pipe_if #(.W(24)) i0 ();
  booth_r4_mult_pipe_if #(.W(16)) i1 ();
  booth_r4_mult_pipe_if #(.W(24)) i2 ();

  booth_r4_mult_pipe #(
    .W(24), .FRAC(22), .PP_PER_STAGE(1)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));

  booth_r4_mult_pipe #(
    .W(16), .FRAC(14), .PP_PER_STAGE(1)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  booth_r4_mult_pipe #(
    .W(24), .FRAC(22), .PP_PER_STAGE(4)
  ) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

  typedef struct {
    longint p;
    bit     sat;
    int     t;
  } exp_t;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [1:0]  m;
    logic [23:0] p;
    bit          sat;
  } dvec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic        last_vo;
  logic        last_sat;
  logic [23:0] last_p;
  bit          last_ro;

  function automatic longint sx(longint v, int w);
    longint one;
    one = longint'(1);
    v = v & ((one << w) - 1);
    return (v >= (one << (w - 1))) ? v - (one << w) : v;
  endfunction

  function automatic exp_t model(
    longint a, longint b, int w, int frac, logic [1:0] m
  );
    longint pr, sc, r, rem, half, q, mx, mn;
    exp_t   e;
    sc   = longint'(1) << frac;
    half = sc / 2;
    pr   = sx(a, w) * sx(b, w);
    r    = pr / sc;
    if (pr < 0 && r * sc != pr) r = r - 1;
    rem  = pr - r * sc;
    q    = r;
    if (m == RND_HALF_UP && rem >= half) q = r + 1;
    if (m == RND_HALF_EVEN &&
        (rem > half || (rem == half && r % 2 != 0)))
      q = r + 1;
    mx    = (longint'(1) << (w - 1)) - 1;
    mn    = -mx - 1;
    e.sat = (q > mx) || (q < mn);
    if (q > mx) q = mx;
    if (q < mn) q = mn;
    e.p = q & ((longint'(1) << w) - 1);
    e.t = 0;
    return e;
  endfunction

  task automatic step0(
    input  bit          v,
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic [1:0]  m,
    input  bit          ro,
    input  bit          chk_lat,
    input  bit          use_c,
    input  logic [23:0] cp,
    input  bit          cs,
    output bit          acc
  );
    exp_t e;
    @(negedge clk);
    if (last_vo && !last_ro) begin
      nvec++;
      if (i0.valid_out !== 1'b1 || i0.p !== last_p ||
          i0.sat !== last_sat) begin
        nerr++;
        $display("FAIL stall_hold: vo=%b p=%h sat=%b, want vo=1 p=%h sat=%b",
                 i0.valid_out, i0.p, i0.sat, last_p, last_sat);
      end
    end
    i0.valid_in  = v;
    i0.a         = a;
    i0.b         = b;
    i0.rnd_mode  = m;
    i0.ready_out = ro;
    #1;
    nvec++;
    if (i0.ready_in !== (!i0.valid_out || ro)) begin
      nerr++;
      $display("FAIL ready_in: got %b, want %b (vo=%b ro=%b)",
               i0.ready_in, !i0.valid_out || ro, i0.valid_out, ro);
    end
    if (i0.valid_out && ro) begin
      n_out0++;
      nvec++;
      if (q0.size() == 0) begin
        nerr++;
        $display("FAIL stale_out: p=%h with nothing expected", i0.p);
      end else begin
        e = q0.pop_front();
        if (i0.p !== e.p[23:0] || i0.sat !== e.sat) begin
          nerr++;
          $display("FAIL result: p=%h sat=%b, want p=%h sat=%b",
                   i0.p, i0.sat, e.p[23:0], e.sat);
        end
        if (chk_lat) begin
          nvec++;
          if (cyc - e.t != 14) begin
            nerr++;
            $display("FAIL latency: got %0d, want 14", cyc - e.t);
          end
        end
      end
    end
    acc = v && i0.ready_in;
    if (acc) begin
      e = model(a, b, 24, 22, m);
      if (use_c) begin
        e.p   = longint'(cp);
        e.sat = cs;
      end
      e.t = cyc;
      q0.push_back(e);
    end
    last_vo  = i0.valid_out;
    last_p   = i0.p;
    last_sat = i0.sat;
    last_ro  = ro;
  endtask

  task automatic drain0(input int maxc, input bit chk_lat);
    bit acc;
    for (int i = 0; i < maxc && q0.size() > 0; i++)
      step0(0, '0, '0, '0, 1, chk_lat, 0, '0, 0, acc);
    nvec++;
    if (q0.size() != 0) begin
      nerr++;
      $display("FAIL drain_timeout: %0d results missing, want 0",
               q0.size());
      q0.delete();
    end
  endtask

  task automatic run_dir(input dvec_t tv[], input bit one_by_one);
    bit acc;
    foreach (tv[i]) begin
      step0(1, tv[i].a, tv[i].b, tv[i].m, 1, 1, 1,
            tv[i].p, tv[i].sat, acc);
      if (one_by_one) drain0(40, 1);
    end
    drain0(40, 1);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec += 4;
    if (i0.valid_out !== 1'b0) begin
      nerr++; $display("FAIL reset_vo: got %b, want 0", i0.valid_out);
    end
    if (i0.p !== 24'h0) begin
      nerr++; $display("FAIL reset_p: got %h, want 0", i0.p);
    end
    if (i0.sat !== 1'b0) begin
      nerr++; $display("FAIL reset_sat: got %b, want 0", i0.sat);
    end
    if (i0.ready_in !== 1'b1) begin
      nerr++; $display("FAIL reset_rdy: got %b, want 1", i0.ready_in);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    dvec_t tv[];
    tv = new[2];
    tv[0] = '{24'h200000, 24'h200000, 2'd0, 24'h100000, 0};
    tv[1] = '{24'hC00000, 24'h600000, 2'd0, 24'hA00000, 0};
    run_dir(tv, 1);
  endtask

  task automatic test_rounding();
    dvec_t tv[];
    tv = new[10];
    tv[0] = '{24'h000001, 24'h200000, 2'd0, 24'h000000, 0};
    tv[1] = '{24'h000001, 24'h200000, 2'd1, 24'h000001, 0};
    tv[2] = '{24'h000001, 24'h200000, 2'd2, 24'h000000, 0};
    tv[3] = '{24'h000003, 24'h200000, 2'd0, 24'h000001, 0};
    tv[4] = '{24'h000003, 24'h200000, 2'd1, 24'h000002, 0};
    tv[5] = '{24'h000003, 24'h200000, 2'd2, 24'h000002, 0};
    tv[6] = '{24'hFFFFFF, 24'h200000, 2'd0, 24'hFFFFFF, 0};
    tv[7] = '{24'hFFFFFF, 24'h200000, 2'd1, 24'h000000, 0};
    tv[8] = '{24'hFFFFFF, 24'h200000, 2'd2, 24'h000000, 0};
    tv[9] = '{24'h000003, 24'h200000, 2'd3, 24'h000001, 0};
    run_dir(tv, 0);
  endtask

  task automatic test_saturation();
    dvec_t tv[];
    tv = new[3];
    tv[0] = '{24'h7FFFFF, 24'h7FFFFF, 2'd0, 24'h7FFFFF, 1};
    tv[1] = '{24'h800000, 24'h800000, 2'd0, 24'h7FFFFF, 1};
    tv[2] = '{24'h800000, 24'h7FFFFF, 2'd0, 24'h800000, 1};
    run_dir(tv, 0);
  endtask

  task automatic test_backpressure();
    logic [23:0] a, b;
    logic [1:0]  m;
    bit          pend, acc, ro;
    int          idx;
    idx    = 0;
    pend   = 0;
    n_out0 = 0;
    a = '0; b = '0; m = '0;
    for (int c = 0; c < 300 && (idx < 40 || q0.size() > 0); c++) begin
      ro = !(c >= 25 && c < 30);
      if (!pend && idx < 40) begin
        a = 24'($urandom);
        b = 24'($urandom);
        m = 2'($urandom);
        pend = 1;
      end
      step0(pend, a, b, m, ro, 0, 0, '0, 0, acc);
      if (acc) begin
        idx++;
        pend = 0;
      end
    end
    nvec++;
    if (n_out0 != 40 || q0.size() != 0) begin
      nerr++;
      $display("FAIL bp_count: got %0d results (%0d pending), want 40",
               n_out0, q0.size());
      q0.delete();
    end
  endtask

  task automatic test_random_stall();
    bit acc;
    for (int i = 0; i < 1500; i++)
      step0($urandom_range(0, 9) < 7, 24'($urandom), 24'($urandom),
            2'($urandom), $urandom_range(0, 9) < 7, 0, 0, '0, 0, acc);
    drain0(100, 0);
  endtask

  task automatic test_reset_midstream();
    bit acc;
    step0(1, 24'h7FFFFF, 24'h7FFFFF, 2'd0, 0, 0, 0, '0, 0, acc);
    for (int i = 0; i < 15; i++)
      step0(1, 24'($urandom), 24'($urandom), 2'($urandom),
            0, 0, 0, '0, 0, acc);
    nvec++;
    if (i0.valid_out !== 1'b1 || i0.p !== 24'h7FFFFF ||
        i0.sat !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset: vo=%b p=%h sat=%b, want 1 7fffff 1",
               i0.valid_out, i0.p, i0.sat);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (i0.valid_out !== 1'b0 || i0.p !== 24'h0 ||
        i0.sat !== 1'b0 || i0.ready_in !== 1'b1) begin
      nerr++;
      $display("FAIL async_reset: vo=%b p=%h sat=%b rdy=%b, want 0 0 0 1",
               i0.valid_out, i0.p, i0.sat, i0.ready_in);
    end
    q0.delete();
    last_vo = 1'b0;
    i0.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    n_out0 = 0;
    step0(1, 24'h200000, 24'h200000, 2'd0, 1, 1, 1,
          24'h100000, 0, acc);
    for (int i = 0; i < 30; i++)
      step0(0, '0, '0, '0, 1, 1, 0, '0, 0, acc);
    nvec++;
    if (n_out0 != 1 || q0.size() != 0) begin
      nerr++;
      $display("FAIL post_reset: got %0d outputs, want 1", n_out0);
      q0.delete();
    end
  endtask

  task automatic test_sweep();
    exp_t   e;
    longint a, b;
    bit     v;
    int     issued, t1, t2;
    logic [1:0] m;
    issued = 0;
    for (int c = 0; c < 14000 && (issued < 10000 ||
         q1.size() > 0 || q2.size() > 0); c++) begin
      v = (issued < 10000) && ($urandom_range(0, 4) != 0);
      a = longint'($urandom);
      b = longint'($urandom);
      m = 2'($urandom);
      @(negedge clk);
      i1.valid_in = v; i1.a = a[15:0]; i1.b = b[15:0];
      i1.rnd_mode = m; i1.ready_out = 1'b1;
      i2.valid_in = v; i2.a = a[23:0]; i2.b = b[23:0];
      i2.rnd_mode = m; i2.ready_out = 1'b1;
      #1;
      nvec++;
      if (i1.ready_in !== 1'b1 || i2.ready_in !== 1'b1) begin
        nerr++;
        $display("FAIL sweep_rdy: got %b/%b, want 1/1",
                 i1.ready_in, i2.ready_in);
      end
      if (i1.valid_out) begin
        nvec++;
        if (q1.size() == 0) begin
          nerr++; $display("FAIL w16_stale: p=%h", i1.p);
        end else begin
          e  = q1.pop_front();
          t1 = cyc - e.t;
          if (i1.p !== e.p[15:0] || i1.sat !== e.sat || t1 != 10) begin
            nerr++;
            $display("FAIL w16: p=%h sat=%b lat=%0d, want p=%h sat=%b lat=10",
                     i1.p, i1.sat, t1, e.p[15:0], e.sat);
          end
        end
      end
      if (i2.valid_out) begin
        nvec++;
        if (q2.size() == 0) begin
          nerr++; $display("FAIL pp4_stale: p=%h", i2.p);
        end else begin
          e  = q2.pop_front();
          t2 = cyc - e.t;
          if (i2.p !== e.p[23:0] || i2.sat !== e.sat || t2 != 5) begin
            nerr++;
            $display("FAIL pp4: p=%h sat=%b lat=%0d, want p=%h sat=%b lat=5",
                     i2.p, i2.sat, t2, e.p[23:0], e.sat);
          end
        end
      end
      if (v) begin
        issued++;
        e = model(a, b, 16, 14, m); e.t = cyc; q1.push_back(e);
        e = model(a, b, 24, 22, m); e.t = cyc; q2.push_back(e);
      end
    end
    nvec++;
    if (issued != 10000 || q1.size() != 0 || q2.size() != 0) begin
      nerr++;
      $display("FAIL sweep_count: issued %0d, pending %0d/%0d, want 10000 0/0",
               issued, q1.size(), q2.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    i0.valid_in = 1'b0; i0.a = '0; i0.b = '0;
    i0.rnd_mode = '0;   i0.ready_out = 1'b1;
    i1.valid_in = 1'b0; i1.a = '0; i1.b = '0;
    i1.rnd_mode = '0;   i1.ready_out = 1'b1;
    i2.valid_in = 1'b0; i2.a = '0; i2.b = '0;
    i2.rnd_mode = '0;   i2.ready_out = 1'b1;
    last_vo = 1'b0; last_p = '0; last_sat = 1'b0; last_ro = 1'b1;
    n_out0 = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_random_stall();
    test_reset_midstream();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
